// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, ALU encodings and
// the all-zero BUBBLE control word used when a slot must not commit.
package pipe_pkg;

    localparam int ALUC_W = 3;
    localparam int CTRL_W = 6 + ALUC_W;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic              regwrite;
        logic              alusrc;
        logic              memwrite;
        logic              memread;
        logic              resultsrc;
        logic              branch;
        logic [ALUC_W-1:0] alucontrol;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector.
// Ports: valid_d/valid_e slot valids, memread_e, rd_e, rs1_d, rs2_d -> lu.
module hazard_detect #(
    parameter int REGW = 5
) (
    input  logic            valid_d,
    input  logic            valid_e,
    input  logic            memread_e,
    input  logic [REGW-1:0] rd_e,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    output logic            lu
);

    // rs2 is compared even for formats that do not read it (conservative).
    assign lu = valid_d & valid_e & memread_e
              & (rd_e != '0)
              & ((rd_e == rs1_d) | (rd_e == rs2_d));

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use bubble, flush and hold.
// Ports: D-stage bundle in, E-stage bundle out, PCSrcE/HoldE, StallD;
// stall_cnt/flush_cnt only exist when PERF_CNT_EN is defined.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic              ALUSrcD,
    input  logic              MemWriteD,
    input  logic              MemReadD,
    input  logic              ResultSrcD,
    input  logic              BranchD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [REGW-1:0]   Rs1D,
    input  logic [REGW-1:0]   Rs2D,
    input  logic [REGW-1:0]   RdD,
    input  logic              PCSrcE,
    input  logic              HoldE,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              ALUSrcE,
    output logic              MemWriteE,
    output logic              MemReadE,
    output logic              ResultSrcE,
    output logic              BranchE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [REGW-1:0]   Rs1E,
    output logic [REGW-1:0]   Rs2E,
    output logic [REGW-1:0]   RdE,
`ifdef PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              StallD
);

    ctrl_t           ctrl_d;
    ctrl_t           ctrl_e;
    logic            valid_e;
    logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e;
    logic [REGW-1:0] rs1_e, rs2_e, rd_e;
    logic            lu;
    logic            bubble;

    assign ctrl_d = '{
        regwrite:   RegWriteD,
        alusrc:     ALUSrcD,
        memwrite:   MemWriteD,
        memread:    MemReadD,
        resultsrc:  ResultSrcD,
        branch:     BranchD,
        alucontrol: ALUControlD
    };

    hazard_detect #(.REGW(REGW)) u_hz (
        .valid_d   (ValidD),
        .valid_e   (valid_e),
        .memread_e (ctrl_e.memread),
        .rd_e      (rd_e),
        .rs1_d     (Rs1D),
        .rs2_d     (Rs2D),
        .lu        (lu)
    );

    // A flush kills the stalled D instruction, so it need not be held.
    assign StallD = HoldE | (lu & ~PCSrcE);
    assign bubble = PCSrcE | lu;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_e <= 1'b0;
            ctrl_e  <= BUBBLE;
            rd1_e   <= '0;
            rd2_e   <= '0;
            imm_e   <= '0;
            pc_e    <= '0;
            rs1_e   <= '0;
            rs2_e   <= '0;
            rd_e    <= '0;
        end else if (!HoldE) begin
            if (bubble) begin
                valid_e <= 1'b0;
                ctrl_e  <= BUBBLE;
                rd1_e   <= '0;
                rd2_e   <= '0;
                imm_e   <= '0;
                pc_e    <= '0;
                rs1_e   <= '0;
                rs2_e   <= '0;
                rd_e    <= '0;
            end else begin
                valid_e <= ValidD;
                // An empty slot carries data but must never commit.
                ctrl_e  <= ValidD ? ctrl_d : BUBBLE;
                rd1_e   <= RD1D;
                rd2_e   <= RD2D;
                imm_e   <= ImmExtD;
                pc_e    <= PCD;
                rs1_e   <= Rs1D;
                rs2_e   <= Rs2D;
                rd_e    <= RdD;
            end
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!HoldE) begin
            if (PCSrcE) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else if (lu) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

    assign ValidE      = valid_e;
    assign RegWriteE   = ctrl_e.regwrite;
    assign ALUSrcE     = ctrl_e.alusrc;
    assign MemWriteE   = ctrl_e.memwrite;
    assign MemReadE    = ctrl_e.memread;
    assign ResultSrcE  = ctrl_e.resultsrc;
    assign BranchE     = ctrl_e.branch;
    assign ALUControlE = ctrl_e.alucontrol;
    assign RD1E        = rd1_e;
    assign RD2E        = rd2_e;
    assign ImmExtE     = imm_e;
    assign PCE         = pc_e;
    assign Rs1E        = rs1_e;
    assign Rs2E        = rs2_e;
    assign RdE         = rd_e;

endmodule
